// File: rtl/db_prbschk_pkg.sv
// Shared types and helpers for the byte-wide PRBS receive checker.
// FSM encoding, default polynomial and an 8-bit popcount used for error counting.
package db_prbschk_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_SYNC   = 2'd3
  } state_e;

  // PRBS15: x^15 + x^14 + 1
  localparam int unsigned DEF_LEN     = 15;
  localparam int unsigned DEF_HIGHEXP = 14;
  localparam int unsigned DEF_LOWEXP  = 13;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/db_prbschk_if.sv
// Stream/monitor bundle between the byte receive path and the PRBS checker.
interface db_prbschk_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             ivld;
  logic [7:0]       idat;
  logic             iclr;
  logic             osync;
  logic             oerr;
  logic [CNT_W-1:0] oerrcnt;

  modport master (
    output ivld, idat, iclr,
    input  osync, oerr, oerrcnt
  );

  modport slave (
    input  ivld, idat, iclr,
    output osync, oerr, oerrcnt
  );

endinterface

// File: rtl/db_prbsbyte_adv.sv
// Combinational 8-step LFSR advance; newest bit in bit 0, so byte_o[7] is the
// earliest bit generated in this byte.
module db_prbsbyte_adv #(
  parameter int unsigned LEN     = 15,
  parameter int unsigned HIGHEXP = 14,
  parameter int unsigned LOWEXP  = 13
) (
  input  logic [LEN-1:0] state_i,
  output logic [LEN-1:0] state_o,
  output logic [7:0]     byte_o
);

  logic [LEN-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < 8; i++) begin
      s = {s[LEN-2:0], s[HIGHEXP] ^ s[LOWEXP]};
    end
  end

  assign state_o = s;
  assign byte_o  = s[7:0];

endmodule

// File: rtl/db_prbschk.sv
// Byte-wide PRBS checker: seeds its LFSR from two received bytes, verifies lock,
// then flywheels and counts bit errors with a saturating counter.
module db_prbschk
  import db_prbschk_pkg::*;
#(
  parameter int unsigned LEN      = DEF_LEN,
  parameter int unsigned HIGHEXP  = DEF_HIGHEXP,
  parameter int unsigned LOWEXP   = DEF_LOWEXP,
  parameter int unsigned SYNC_THR = 4,
  parameter int unsigned LOSS_THR = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  db_prbschk_if.slave  bus_if
);

  state_e           state_q, state_d;
  logic [LEN-1:0]   lfsr_q, lfsr_d, lfsr_adv;
  logic [LEN-9:0]   hold_q, hold_d;
  logic [3:0]       goodcnt_q, goodcnt_d;
  logic [3:0]       badcnt_q, badcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]       exp_byte;
  logic [7:0]       diff;
  logic [3:0]       diff_pc;
  logic [CNT_W:0]   sum;

  db_prbsbyte_adv #(
    .LEN     (LEN),
    .HIGHEXP (HIGHEXP),
    .LOWEXP  (LOWEXP)
  ) u_adv (
    .state_i (lfsr_q),
    .state_o (lfsr_adv),
    .byte_o  (exp_byte)
  );

  assign diff    = bus_if.idat ^ exp_byte;
  assign diff_pc = popcount8(diff);
  // One extra bit catches the carry out so saturation is a single-bit test.
  assign sum     = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(diff_pc);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    hold_d    = hold_q;
    goodcnt_d = goodcnt_q;
    badcnt_d  = badcnt_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    if (bus_if.ivld) begin
      unique case (state_q)
        ST_HUNT: begin
          hold_d  = bus_if.idat[LEN-9:0];
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          lfsr_d    = {hold_q, bus_if.idat};
          goodcnt_d = '0;
          state_d   = ST_VERIFY;
        end
        ST_VERIFY: begin
          lfsr_d = lfsr_adv;
          if (diff == '0) begin
            goodcnt_d = goodcnt_q + 4'd1;
            if (goodcnt_d == 4'(SYNC_THR)) begin
              state_d  = ST_SYNC;
              badcnt_d = '0;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_SYNC: begin
          // Flywheel: the LFSR keeps running from its own state, never from data.
          lfsr_d = lfsr_adv;
          if (diff != '0) begin
            err_d    = 1'b1;
            badcnt_d = badcnt_q + 4'd1;
            if (badcnt_d == 4'(LOSS_THR)) begin
              state_d = ST_HUNT;
            end
          end else begin
            badcnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (bus_if.iclr) begin
      cnt_d = err_d ? CNT_W'(diff_pc) : '0;
    end else if (err_d) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      lfsr_q    <= '0;
      hold_q    <= '0;
      goodcnt_q <= '0;
      badcnt_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      hold_q    <= hold_d;
      goodcnt_q <= goodcnt_d;
      badcnt_q  <= badcnt_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus_if.osync   = (state_q == ST_SYNC);
  assign bus_if.oerr    = err_q;
  assign bus_if.oerrcnt = cnt_q;

endmodule

// File: tb/tb_db_prbschk.sv
// Bench for db_prbschk: a 16-bit and a 4-bit counter instance share one stimulus
// stream and are checked every cycle against a bit-serial PRBS reference model.
module tb_db_prbschk;

  localparam int LEN      = 15;
  localparam int HI       = 14;
  localparam int LO       = 13;
  localparam int SYNC_THR = 4;
  localparam int LOSS_THR = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  db_prbschk_if #(.CNT_W(16)) bus16 ();
  db_prbschk_if #(.CNT_W(4))  bus4 ();

  assign bus4.ivld = bus16.ivld;
  assign bus4.idat = bus16.idat;
  assign bus4.iclr = bus16.iclr;

  db_prbschk #(
    .LEN(LEN), .HIGHEXP(HI), .LOWEXP(LO),
    .SYNC_THR(SYNC_THR), .LOSS_THR(LOSS_THR), .CNT_W(16)
  ) u_dut16 (
    .clk(clk), .rst(rst), .bus_if(bus16)
  );

  db_prbschk #(
    .LEN(LEN), .HIGHEXP(HI), .LOWEXP(LO),
    .SYNC_THR(SYNC_THR), .LOSS_THR(LOSS_THR), .CNT_W(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus_if(bus4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transmit-side PRBS source: bit history, oldest first.
  bit g_hist[$];

  task automatic gen_seed();
    g_hist = {};
    repeat (LEN) g_hist.push_back(1'b1);
  endtask

  task automatic gen_byte(output logic [7:0] b);
    bit f;
    for (int i = 7; i >= 0; i--) begin
      f = g_hist[LEN-1-HI] ^ g_hist[LEN-1-LO];
      g_hist.push_back(f);
      void'(g_hist.pop_front());
      b[i] = f;
    end
  endtask

  // Receiver reference: mode 0 hunt, 1 load, 2 verify, 3 locked.
  int         m_mode;
  logic [7:0] m_hold;
  bit         m_hist[$];
  int         m_good, m_bad;
  logic       m_err;
  int         m_c16, m_c4;

  task automatic model_reset();
    m_mode = 0; m_hold = '0; m_good = 0; m_bad = 0; m_err = 1'b0;
    m_c16 = 0; m_c4 = 0;
    m_hist = {};
    repeat (LEN) m_hist.push_back(1'b0);
  endtask

  task automatic ref_byte(output logic [7:0] b);
    bit f;
    for (int i = 7; i >= 0; i--) begin
      f = m_hist[LEN-1-HI] ^ m_hist[LEN-1-LO];
      m_hist.push_back(f);
      void'(m_hist.pop_front());
      b[i] = f;
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic [7:0]  e;
    logic [15:0] w;
    int          pc;
    pc = 0;
    m_err = 1'b0;
    if (v) begin
      case (m_mode)
        0: begin m_hold = d; m_mode = 1; end
        1: begin
          w = {m_hold, d};
          m_hist = {};
          for (int i = LEN-1; i >= 0; i--) m_hist.push_back(w[i]);
          m_good = 0;
          m_mode = 2;
        end
        2: begin
          ref_byte(e);
          if (e == d) begin
            m_good++;
            if (m_good == SYNC_THR) begin m_mode = 3; m_bad = 0; end
          end else m_mode = 0;
        end
        default: begin
          ref_byte(e);
          if (e != d) begin
            m_err = 1'b1;
            pc = $countones(e ^ d);
            m_bad++;
            if (m_bad == LOSS_THR) m_mode = 0;
          end else m_bad = 0;
        end
      endcase
    end
    if (c) begin
      m_c16 = pc;
      m_c4  = pc;
    end else begin
      m_c16 = (m_c16 + pc > 65535) ? 65535 : m_c16 + pc;
      m_c4  = (m_c4 + pc > 15) ? 15 : m_c4 + pc;
    end
  endtask

  task automatic check_all();
    chk("osync",   32'(bus16.osync),   32'(m_mode == 3));
    chk("oerr",    32'(bus16.oerr),    32'(m_err));
    chk("cnt16",   32'(bus16.oerrcnt), 32'(m_c16));
    chk("osync4",  32'(bus4.osync),    32'(m_mode == 3));
    chk("oerr4",   32'(bus4.oerr),     32'(m_err));
    chk("cnt4",    32'(bus4.oerrcnt),  32'(m_c4));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    bus16.ivld = v;
    bus16.idat = d;
    bus16.iclr = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] mask, input logic c);
    logic [7:0] b;
    gen_byte(b);
    cyc(1'b1, b ^ mask, c);
  endtask

  task automatic idle();
    cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1'b1;
    bus16.ivld = v;
    bus16.idat = 8'($urandom);
    bus16.iclr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    chk("rst_osync", 32'(bus16.osync), 32'd0);
    chk("rst_cnt",   32'(bus16.oerrcnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] first_byte;
  int         saved_cnt;

  initial begin
    rst = 1'b1;
    bus16.ivld = 1'b0;
    bus16.idat = '0;
    bus16.iclr = 1'b0;
    model_reset();
    gen_seed();
    do_reset(1'b0);

    // Known start of the PRBS15 sequence from an all-ones seed.
    gen_byte(first_byte);
    chk("gen_b0", 32'(first_byte), 32'h00);
    gen_seed();

    // Clean stream: lock one cycle after the 6th byte, no errors for 1000 bytes.
    for (int i = 1; i <= 1000; i++) begin
      send(8'h00, 1'b0);
      if (i == 5) chk("lock_not5", 32'(bus16.osync), 32'd0);
      if (i == 6) chk("lock_at6",  32'(bus16.osync), 32'd1);
    end
    chk("clean_cnt", 32'(bus16.oerrcnt), 32'd0);

    // Single-bit then full-byte error while locked.
    send(8'h01, 1'b0);
    chk("err1_pulse", 32'(bus16.oerr), 32'd1);
    chk("err1_cnt",   32'(bus16.oerrcnt), 32'd1);
    send(8'hFF, 1'b0);
    chk("err9_cnt",   32'(bus16.oerrcnt), 32'd9);
    chk("err9_sync",  32'(bus16.osync), 32'd1);
    send(8'h00, 1'b0);
    chk("err_once",   32'(bus16.oerr), 32'd0);

    // Three consecutive bad bytes drop lock; clean stream relocks in 6 bytes.
    for (int i = 1; i <= 3; i++) begin
      send(8'($urandom_range(1, 255)), 1'b0);
      if (i == 2) chk("loss_hold2", 32'(bus16.osync), 32'd1);
      if (i == 3) chk("loss_at3",   32'(bus16.osync), 32'd0);
    end
    for (int i = 1; i <= 6; i++) begin
      send(8'h00, 1'b0);
      if (i == 5) chk("relock_not5", 32'(bus16.osync), 32'd0);
      if (i == 6) chk("relock_at6",  32'(bus16.osync), 32'd1);
    end

    // Drop lock again, then relock on a gapped stream.
    repeat (3) send(8'h5A, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      idle();
      idle();
      chk("gap_noerr", 32'(bus16.oerr), 32'd0);
      send(8'h00, 1'b0);
      if (i == 5) chk("gap_not5", 32'(bus16.osync), 32'd0);
      if (i == 6) chk("gap_at6",  32'(bus16.osync), 32'd1);
    end

    // Saturation of the 4-bit counter and clear with a coincident error.
    send(8'h00, 1'b1);
    chk("clr_cnt", 32'(bus16.oerrcnt), 32'd0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    chk("sat_cnt4",  32'(bus4.oerrcnt),  32'hF);
    chk("sat_cnt16", 32'(bus16.oerrcnt), 32'd16);
    send(8'h10, 1'b1);
    chk("clr_err_cnt4",  32'(bus4.oerrcnt),  32'd1);
    chk("clr_err_cnt16", 32'(bus16.oerrcnt), 32'd1);

    // Mismatch on the 2nd verify byte returns to hunt without counting.
    saved_cnt = m_c16;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h80, 1'b0);
    chk("vfail_sync", 32'(bus16.osync), 32'd0);
    chk("vfail_cnt",  32'(bus16.oerrcnt), 32'(saved_cnt));
    repeat (4) send(8'h00, 1'b0);
    chk("vfail_nolock", 32'(bus16.osync), 32'd0);

    // Randomised traffic: gaps, sparse corruption, occasional clears.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        send(($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
             1'($urandom_range(0, 49) == 0));
      end else begin
        cyc(1'b0, 8'($urandom), 1'($urandom_range(0, 49) == 0));
      end
    end

    // Reset while locked clears everything on the next edge.
    repeat (12) send(8'h00, 1'b0);
    chk("pre_rst_sync", 32'(bus16.osync), 32'd1);
    send(8'h03, 1'b0);
    do_reset(1'b1);
    chk("rst_oerr", 32'(bus16.oerr), 32'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
